// File: rtl/riscv_run_pkg.sv
// Shared types and constants for the RISC-V run controller: FSM state encoding
// and the default completion-mailbox address.
package riscv_run_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_HOLD,
    ST_RUN,
    ST_DONE
  } run_state_e;

  localparam logic [31:0] TOHOST_ADDR_DEFAULT = 32'h0000_0FFC;

endpackage

// File: rtl/riscv_sat_counter.sv
// Width-parameterised up-counter with synchronous clear and enable.
// The count sticks at all-ones instead of wrapping.
module riscv_sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value regardless of block evaluation order.
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/riscv_run_ctrl.sv
// Test-harness controller for a RISC-V core: streams a program into instruction
// memory, holds the core in reset, runs it and watches the tohost mailbox.
module riscv_run_ctrl
  import riscv_run_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter int              IMEM_AW      = 8,
  parameter int              RESET_CYCLES = 2,
  parameter int              TIMEOUT      = 1000,
  parameter int              CNT_W        = 32,
  parameter logic [XLEN-1:0] TOHOST_ADDR  = XLEN'(TOHOST_ADDR_DEFAULT)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               ld_valid,
  output logic               ld_ready,
  input  logic [31:0]        ld_data,
  input  logic               ld_last,
  output logic               imem_we,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic [31:0]        imem_wdata,
  output logic               core_reset,
  input  logic               retire,
  input  logic               dmem_we,
  input  logic [XLEN-1:0]    dmem_addr,
  input  logic [XLEN-1:0]    dmem_wdata,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic               timeout,
  output logic [XLEN-2:0]    exit_code,
  output logic [CNT_W-1:0]   cycle_count,
  output logic [CNT_W-1:0]   retire_count
);

  // A zero-length hold would skip the core reset entirely, so clamp to one.
  localparam int                 HOLD_N       = (RESET_CYCLES < 1) ? 1 : RESET_CYCLES;
  localparam int                 HOLD_W       = $clog2(HOLD_N + 1);
  localparam logic [HOLD_W-1:0]  HOLD_LAST    = HOLD_W'(HOLD_N - 1);
  localparam logic [IMEM_AW-1:0] ADDR_MAX     = '1;
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);

  run_state_e         state_q;
  logic [IMEM_AW-1:0] addr_q;
  logic [HOLD_W-1:0]  hold_q;
  logic               pass_q;
  logic               timeout_q;
  logic [XLEN-2:0]    exit_q;

  logic launch;
  logic xfer;
  logic tohost_hit;
  logic run_expired;

  assign launch      = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign xfer        = ld_valid && ld_ready;
  assign tohost_hit  = dmem_we && (dmem_addr == TOHOST_ADDR) && (dmem_wdata != '0);
  // Evaluated before this cycle's increment: the TIMEOUT-th run cycle is the last.
  assign run_expired = (cycle_count >= TIMEOUT_LAST);

  // NOTE: the asynchronous reset clears only control flops; the instruction
  // memory lives outside this block and its contents are never reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      hold_q    <= '0;
      pass_q    <= 1'b0;
      timeout_q <= 1'b0;
      exit_q    <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_q   <= ST_LOAD;
            addr_q    <= '0;
            pass_q    <= 1'b0;
            timeout_q <= 1'b0;
            exit_q    <= '0;
          end
        end
        ST_LOAD: begin
          if (xfer) begin
            if (addr_q != ADDR_MAX) begin
              addr_q <= addr_q + IMEM_AW'(1);
            end
            // A full memory ends the load as if ld_last had been seen.
            if (ld_last || (addr_q == ADDR_MAX)) begin
              state_q <= ST_HOLD;
              hold_q  <= '0;
            end
          end
        end
        ST_HOLD: begin
          if (hold_q == HOLD_LAST) begin
            state_q <= ST_RUN;
          end else begin
            hold_q <= hold_q + HOLD_W'(1);
          end
        end
        ST_RUN: begin
          if (tohost_hit) begin
            pass_q  <= (dmem_wdata == XLEN'(1));
            exit_q  <= dmem_wdata[XLEN-1:1];
            state_q <= ST_DONE;
          end else if (run_expired) begin
            timeout_q <= 1'b1;
            state_q   <= ST_DONE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  riscv_sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .rst_i (reset),
    .clr_i (launch),
    .en_i  (state_q == ST_RUN),
    .cnt_o (cycle_count)
  );

  riscv_sat_counter #(.W(CNT_W)) u_retire_cnt (
    .clk   (clk),
    .rst_i (reset),
    .clr_i (launch),
    .en_i  ((state_q == ST_RUN) && retire),
    .cnt_o (retire_count)
  );

  assign ld_ready   = (state_q == ST_LOAD);
  assign imem_we    = xfer;
  assign imem_addr  = addr_q;
  assign imem_wdata = ld_data;
  assign core_reset = (state_q != ST_RUN);
  assign busy       = (state_q == ST_LOAD) || (state_q == ST_HOLD) || (state_q == ST_RUN);
  assign done       = (state_q == ST_DONE);
  assign pass       = pass_q;
  assign timeout    = timeout_q;
  assign exit_code  = exit_q;

endmodule

// File: doc/riscv_run_ctrl.md
RISCV_RUN_CTRL -- requirements
Module: riscv_run_ctrl

Interface
REQ-001 The block SHALL take parameter XLEN, default 32, as the core data and address width.
REQ-002 The block SHALL take parameter IMEM_AW, default 8, as the instruction-memory word-address width (2**IMEM_AW words).
REQ-003 The block SHALL take parameter RESET_CYCLES, default 2, as the number of cycles the core reset is held after load.
REQ-004 The block SHALL take parameter TIMEOUT, default 1000, as the maximum number of run cycles before abort.
REQ-005 The block SHALL take parameter CNT_W, default 32, as the cycle and retire counter width.
REQ-006 The block SHALL take parameter TOHOST_ADDR, default 32'h0000_0FFC, as the completion-mailbox data address.
REQ-007 Ports SHALL be as follows: clk  in  1  single clock, rising edge.
REQ-008 reset  in  1  asynchronous, active-high.
REQ-009 start  in  1  one-cycle pulse, begin load/run sequence.
REQ-010 ld_valid/ld_ready  in/out  1  program-load stream handshake; ld_data  in  32  instruction word; ld_last  in  1  final word.
REQ-011 imem_we  out  1; imem_addr  out  IMEM_AW; imem_wdata  out  32  instruction-memory write port.
REQ-012 core_reset  out  1  active-high reset to the core under control.
REQ-013 retire  in  1  one instruction retired this cycle.
REQ-014 dmem_we  in  1; dmem_addr  in  XLEN; dmem_wdata  in  XLEN  core data-store snoop.
REQ-015 busy, done, pass, timeout  out  1 each; exit_code  out  XLEN-1; cycle_count, retire_count  out  CNT_W.

Function
REQ-016 FSM states SHALL be IDLE, LOAD, HOLD, RUN, DONE.
REQ-017 IDLE: core_reset=1, ld_ready=0; on start go to LOAD, clear addresses, counters and result flags.
REQ-018 LOAD: ld_ready=1; each cycle with ld_valid&ld_ready SHALL assert imem_we combinationally with imem_wdata=ld_data at imem_addr, then increment imem_addr.
REQ-019 LOAD: a transfer with ld_last=1 SHALL move to HOLD next cycle; a transfer at imem_addr=2**IMEM_AW-1 without ld_last SHALL also move to HOLD (write accepted, no wrap).
REQ-020 HOLD: core_reset=1 for exactly RESET_CYCLES cycles (RESET_CYCLES=0 treated as 1), then RUN.
REQ-021 RUN: core_reset=0; cycle_count increments every RUN cycle; retire_count increments on each retire=1 cycle; both saturate at all-ones.
REQ-022 RUN: dmem_we=1 with dmem_addr==TOHOST_ADDR and dmem_wdata!=0 SHALL end the run: pass=(dmem_wdata==1), exit_code=dmem_wdata[XLEN-1:1], go to DONE.
REQ-023 Tohost stores of value 0 and stores to other addresses SHALL be ignored.
REQ-024 RUN: when cycle_count reaches TIMEOUT with no valid tohost store, timeout=1, pass=0, go to DONE; a tohost store in that same cycle SHALL win (timeout=0).
REQ-025 DONE: core_reset=1, done=1; counters and result frozen until next start, which returns to LOAD.
REQ-026 start SHALL be ignored in LOAD, HOLD and RUN.
REQ-027 busy SHALL be 1 in LOAD, HOLD, RUN, else 0.
REQ-028 retire in the same cycle as the ending tohost store SHALL be counted.

Reset
REQ-029 Asserting reset at any time SHALL force IDLE within the same cycle: core_reset=1, ld_ready=0, imem_we=0, busy/done/pass/timeout=0, exit_code=0, counters=0, imem_addr=0.
REQ-030 Reset mid-LOAD or mid-RUN SHALL discard partial state; a later start restarts from imem_addr 0.

Structure
REQ-031 The state enum and the default TOHOST_ADDR constant SHALL live in a shared package riscv_run_pkg.
REQ-032 One sub-module riscv_sat_counter (width-parameterised, enable, clear, saturating) SHALL be used for cycle_count and retire_count.

Verification
REQ-033 Load 4 words, ld_last on 4th -> imem writes addr 0..3, HOLD exactly 2 cycles, then core_reset=0.
REQ-034 In RUN, store 1 to 0xFFC after 37 cycles with 25 retires -> done=1, pass=1, exit_code=0, cycle_count=37, retire_count=25.
REQ-035 Store 0x7 to 0xFFC -> pass=0, exit_code=3; store 0 to 0xFFC earlier -> ignored.
REQ-036 TIMEOUT=50, no tohost store -> timeout=1 at cycle_count=50; tohost store exactly at cycle 50 -> pass, timeout=0.
REQ-037 IMEM_AW=2, 6 words without ld_last -> 4 writes accepted, HOLD entered, addr not wrapped.
REQ-038 reset during RUN at cycle 10 -> IDLE, all outputs at reset values; new start reloads from addr 0.
